// File: rtl/hilo_mult_unit_if.sv
// Handshake and data bundle between the EX stage and the HI/LO multiply unit.
// The pipeline side drives requests and mthi/mtlo writes. The unit returns status and the architectural registers.
interface hilo_mult_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [4:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             HiWrite;
    logic             LoWrite;
    logic [WIDTH-1:0] WrData;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    logic [WIDTH-1:0] MulResult;

    modport master (
        output Start, ALUControl, A, B, HiWrite, LoWrite, WrData,
        input  Busy, Done, Hi, Lo, MulResult
    );

    modport slave (
        input  Start, ALUControl, A, B, HiWrite, LoWrite, WrData,
        output Busy, Done, Hi, Lo, MulResult
    );
endinterface

// File: rtl/hilo_mult_unit.sv
// Multi-cycle radix-2 shift-add multiply/accumulate unit that owns the HI/LO pair.
// It handles MULT, MULTU, MUL, MADD and MSUB, and applies the sign fix-up in a final FIX cycle.
module hilo_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    hilo_mult_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_MULT  = 5'b00011;
    localparam logic [4:0] OP_MULTU = 5'b00100;
    localparam logic [4:0] OP_MUL   = 5'b10011;
    localparam logic [4:0] OP_MADD  = 5'b10100;
    localparam logic [4:0] OP_MSUB  = 5'b10101;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic is_mult_op(input logic [4:0] code);
        case (code)
            OP_MULT, OP_MULTU, OP_MUL, OP_MADD, OP_MSUB: is_mult_op = 1'b1;
            default:                                     is_mult_op = 1'b0;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        if (v[WIDTH-1]) begin
            magnitude = ~v + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            magnitude = v;
        end
    endfunction

    state_t             state_r,   state_s;
    logic [4:0]         op_r,      op_s;
    logic [2*WIDTH-1:0] mcand_r,   mcand_s;
    logic [WIDTH-1:0]   mplier_r,  mplier_s;
    logic               neg_r,     neg_s;
    logic [2*WIDTH-1:0] partial_r, partial_s;
    logic [CW-1:0]      cnt_r,     cnt_s;
    logic [WIDTH-1:0]   hi_r,      hi_s;
    logic [WIDTH-1:0]   lo_r,      lo_s;
    logic [WIDTH-1:0]   mulres_r,  mulres_s;
    logic               done_r,    done_s;
    logic               busy_r,    busy_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH-1:0] acc_s;

    // Next-state, datapath and HI/LO update decode.
    always_comb begin
        state_s   = state_r;
        op_s      = op_r;
        mcand_s   = mcand_r;
        mplier_s  = mplier_r;
        neg_s     = neg_r;
        partial_s = partial_r;
        cnt_s     = cnt_r;
        hi_s      = hi_r;
        lo_s      = lo_r;
        mulres_s  = mulres_r;
        done_s    = 1'b0;
        busy_s    = busy_r;
        acc_s     = {hi_r, lo_r};
        if (neg_r) begin
            prod_s = ~partial_r + {{(2*WIDTH-1){1'b0}}, 1'b1};
        end else begin
            prod_s = partial_r;
        end

        case (state_r)
            IDLE: begin
                // mthi/mtlo are only honoured here, so they land no later than E0.
                if (bus.HiWrite) begin
                    hi_s = bus.WrData;
                end else begin
                    hi_s = hi_r;
                end
                if (bus.LoWrite) begin
                    lo_s = bus.WrData;
                end else begin
                    lo_s = lo_r;
                end
                if (bus.Start && is_mult_op(bus.ALUControl)) begin
                    op_s = bus.ALUControl;
                    if (bus.ALUControl == OP_MULTU) begin
                        mcand_s  = {{WIDTH{1'b0}}, bus.A};
                        mplier_s = bus.B;
                        neg_s    = 1'b0;
                    end else begin
                        mcand_s  = {{WIDTH{1'b0}}, magnitude(bus.A)};
                        mplier_s = magnitude(bus.B);
                        neg_s    = bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                    end
                    partial_s = {(2*WIDTH){1'b0}};
                    cnt_s     = CW'(WIDTH);
                    state_s   = CALC;
                    busy_s    = 1'b1;
                end else begin
                    state_s = IDLE;
                    busy_s  = 1'b0;
                end
            end
            CALC: begin
                // Shifting the multiplicand left each step is equivalent to adding mcand << bit index.
                if (mplier_r[0]) begin
                    partial_s = partial_r + mcand_r;
                end else begin
                    partial_s = partial_r;
                end
                mcand_s  = mcand_r << 1;
                mplier_s = mplier_r >> 1;
                cnt_s    = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    state_s = FIX;
                end else begin
                    state_s = CALC;
                end
                busy_s = 1'b1;
            end
            FIX: begin
                case (op_r)
                    OP_MULT, OP_MULTU: {hi_s, lo_s} = prod_s;
                    OP_MADD:           {hi_s, lo_s} = acc_s + prod_s;
                    OP_MSUB:           {hi_s, lo_s} = acc_s - prod_s;
                    OP_MUL:            mulres_s     = prod_s[WIDTH-1:0];
                    default:           mulres_s     = mulres_r;
                endcase
                done_s  = 1'b1;
                busy_s  = 1'b0;
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_r   <= IDLE;
            op_r      <= 5'b00000;
            mcand_r   <= {(2*WIDTH){1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            neg_r     <= 1'b0;
            partial_r <= {(2*WIDTH){1'b0}};
            cnt_r     <= {CW{1'b0}};
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
            mulres_r  <= {WIDTH{1'b0}};
            done_r    <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            op_r      <= op_s;
            mcand_r   <= mcand_s;
            mplier_r  <= mplier_s;
            neg_r     <= neg_s;
            partial_r <= partial_s;
            cnt_r     <= cnt_s;
            hi_r      <= hi_s;
            lo_r      <= lo_s;
            mulres_r  <= mulres_s;
            done_r    <= done_s;
            busy_r    <= busy_s;
        end
    end

    assign bus.Busy      = busy_r;
    assign bus.Done      = done_r;
    assign bus.Hi        = hi_r;
    assign bus.Lo        = lo_r;
    assign bus.MulResult = mulres_r;
endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: directed vector table, hand-written corner sequences,
// and randomized operations against a 64-bit arithmetic reference model.
module tb_hilo_mult_unit;
    localparam logic [4:0] OP_MULT  = 5'b00011;
    localparam logic [4:0] OP_MULTU = 5'b00100;
    localparam logic [4:0] OP_MUL   = 5'b10011;
    localparam logic [4:0] OP_MADD  = 5'b10100;
    localparam logic [4:0] OP_MSUB  = 5'b10101;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          pre;
        logic [31:0] pre_hi;
        logic [31:0] pre_lo;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        logic [31:0] exp_mul;
    } vec_t;

    logic Clk;
    logic Rst;
    hilo_mult_unit_if #(.WIDTH(32)) bus ();

    hilo_mult_unit #(.WIDTH(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi, m_lo, m_mul;
    vec_t vecs [8];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [63:0] ref_prod(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (op == OP_MULTU) begin
            return {32'd0, a} * {32'd0, b};
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    task automatic model_apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p, acc;
        p = ref_prod(op, a, b);
        acc = {m_hi, m_lo};
        case (op)
            OP_MULT, OP_MULTU: {m_hi, m_lo} = p;
            OP_MADD:           {m_hi, m_lo} = acc + p;
            OP_MSUB:           {m_hi, m_lo} = acc - p;
            OP_MUL:            m_mul = p[31:0];
            default:           m_mul = m_mul;
        endcase
    endtask

    task automatic preload(input logic [31:0] hi, input logic [31:0] lo);
        bus.HiWrite = 1'b1;
        bus.WrData  = hi;
        tick();
        bus.HiWrite = 1'b0;
        bus.LoWrite = 1'b1;
        bus.WrData  = lo;
        tick();
        bus.LoWrite = 1'b0;
        m_hi = hi;
        m_lo = lo;
    endtask

    task automatic wait_done(output int cyc, output bit found);
        found = 1'b0;
        cyc   = 0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            cyc++;
            if (bus.Done) found = 1'b1;
        end
    endtask

    // Issues one operation, scrambles A/B after E0, and checks Busy, latency and Done width.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        int cyc;
        bit busy_ok;
        bit found;
        bus.Start      = 1'b1;
        bus.ALUControl = op;
        bus.A          = a;
        bus.B          = b;
        tick();
        bus.Start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        check({tag, " busy after E0"}, 64'(bus.Busy), 64'd1);
        busy_ok = 1'b1;
        cyc     = 0;
        found   = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            tick();
            cyc++;
            if (bus.Done) found = 1'b1;
            else if (!bus.Busy) busy_ok = 1'b0;
        end
        check({tag, " latency"}, 64'(cyc), 64'd33);
        check({tag, " busy held"}, 64'(busy_ok), 64'd1);
        check({tag, " busy low at done"}, 64'(bus.Busy), 64'd0);
        tick();
        check({tag, " done one cycle"}, 64'(bus.Done), 64'd0);
    endtask

    initial begin
        int cyc;
        int dones;
        int busies;
        bit found;
        logic [4:0] codes [5];
        logic [4:0] op;
        logic [31:0] a, b;

        codes[0] = OP_MULT; codes[1] = OP_MULTU; codes[2] = OP_MUL;
        codes[3] = OP_MADD; codes[4] = OP_MSUB;

        vecs[0] = '{OP_MULT,  32'hFFFFFFFD, 32'h00000007, 1'b1, 32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFEB, 32'h0};
        vecs[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0,  32'hFFFFFFFE, 32'h00000001, 32'h0};
        vecs[2] = '{OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h0,  32'h00000000, 32'h00000001, 32'h0};
        vecs[3] = '{OP_MADD,  32'h00000005, 32'h00000006, 1'b1, 32'h0, 32'd10, 32'h00000000, 32'h00000028, 32'h0};
        vecs[4] = '{OP_MSUB,  32'hFFFFFFFF, 32'h00000028, 1'b0, 32'h0, 32'h0,  32'h00000000, 32'h00000050, 32'h0};
        vecs[5] = '{OP_MSUB,  32'h00000001, 32'h00000001, 1'b1, 32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[6] = '{OP_MUL,   32'h00010000, 32'h00010000, 1'b0, 32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        vecs[7] = '{OP_MUL,   32'h00000007, 32'hFFFFFFFE, 1'b0, 32'h0, 32'h0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF2};

        Rst = 1'b0;
        bus.Start = 1'b0; bus.ALUControl = 5'b00000; bus.A = 32'h0; bus.B = 32'h0;
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0; bus.WrData = 32'h0;
        tick(); tick();
        check("reset busy", 64'(bus.Busy), 64'd0);
        check("reset done", 64'(bus.Done), 64'd0);
        check("reset hi", 64'(bus.Hi), 64'd0);
        check("reset lo", 64'(bus.Lo), 64'd0);
        check("reset mul", 64'(bus.MulResult), 64'd0);
        Rst = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].pre) preload(vecs[i].pre_hi, vecs[i].pre_lo);
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
            check($sformatf("vec%0d hi", i), 64'(bus.Hi), 64'(vecs[i].exp_hi));
            check($sformatf("vec%0d lo", i), 64'(bus.Lo), 64'(vecs[i].exp_lo));
            check($sformatf("vec%0d mul", i), 64'(bus.MulResult), 64'(vecs[i].exp_mul));
        end

        // Start and HiWrite while busy are both dropped.
        preload(32'h0, 32'h0);
        bus.Start = 1'b1; bus.ALUControl = OP_MULT; bus.A = 32'd2; bus.B = 32'd3;
        tick();
        bus.Start = 1'b0;
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 5) begin
                bus.Start = 1'b1; bus.ALUControl = OP_MULTU; bus.A = 32'd9; bus.B = 32'd9;
                bus.HiWrite = 1'b1; bus.WrData = 32'hAA;
            end else begin
                bus.Start = 1'b0; bus.HiWrite = 1'b0;
            end
            tick();
            if (bus.Done) dones++;
        end
        check("busy-ignore done count", 64'(dones), 64'd1);
        check("busy-ignore hi", 64'(bus.Hi), 64'd0);
        check("busy-ignore lo", 64'(bus.Lo), 64'd6);

        // Back-to-back: Start plus mthi in the Done cycle, then MADD onto the written HI.
        bus.Start = 1'b1; bus.ALUControl = OP_MULTU; bus.A = 32'd3; bus.B = 32'd4;
        tick();
        bus.Start = 1'b0;
        wait_done(cyc, found);
        check("b2b first done", 64'(found), 64'd1);
        check("b2b first lo", 64'(bus.Lo), 64'd12);
        bus.Start = 1'b1; bus.ALUControl = OP_MADD; bus.A = 32'hFFFFFFFE; bus.B = 32'd5;
        bus.HiWrite = 1'b1; bus.WrData = 32'h55;
        tick();
        bus.Start = 1'b0; bus.HiWrite = 1'b0;
        check("b2b done falls", 64'(bus.Done), 64'd0);
        check("b2b accepted", 64'(bus.Busy), 64'd1);
        check("b2b hi at E0", 64'(bus.Hi), 64'h55);
        wait_done(cyc, found);
        check("b2b second latency", 64'(cyc), 64'd33);
        check("b2b madd hi", 64'(bus.Hi), 64'h55);
        check("b2b madd lo", 64'(bus.Lo), 64'd2);

        // Start during FIX is not sampled.
        preload(32'h0, 32'h0);
        bus.Start = 1'b1; bus.ALUControl = OP_MULT; bus.A = 32'd2; bus.B = 32'd2;
        tick();
        bus.Start = 1'b0;
        for (int k = 0; k < 32; k++) tick();
        bus.Start = 1'b1; bus.ALUControl = OP_MULTU; bus.A = 32'd7; bus.B = 32'd7;
        tick();
        bus.Start = 1'b0;
        check("fix-start done", 64'(bus.Done), 64'd1);
        tick();
        check("fix-start not accepted", 64'(bus.Busy), 64'd0);
        check("fix-start lo", 64'(bus.Lo), 64'd4);

        // Unknown code is ignored.
        bus.Start = 1'b1; bus.ALUControl = 5'b00000; bus.A = 32'd5; bus.B = 32'd5;
        tick();
        bus.Start = 1'b0;
        check("bad code busy", 64'(bus.Busy), 64'd0);
        dones = 0;
        for (int k = 0; k < 36; k++) begin
            tick();
            if (bus.Done) dones++;
        end
        check("bad code no done", 64'(dones), 64'd0);
        check("bad code lo kept", 64'(bus.Lo), 64'd4);

        // Randomized ops against the arithmetic model.
        m_mul = 32'hFFFFFFF2;
        for (int i = 0; i < 24; i++) begin
            if (i % 6 == 0) preload($urandom, $urandom);
            op = codes[$urandom_range(0, 4)];
            a  = (i % 8 == 3) ? 32'h80000000 : 32'($urandom);
            b  = (i % 8 == 5) ? 32'h80000000 : 32'($urandom);
            run_op(op, a, b, $sformatf("rnd%0d", i));
            model_apply(op, a, b);
            check($sformatf("rnd%0d hi", i), 64'(bus.Hi), 64'(m_hi));
            check($sformatf("rnd%0d lo", i), 64'(bus.Lo), 64'(m_lo));
            check($sformatf("rnd%0d mul", i), 64'(bus.MulResult), 64'(m_mul));
        end

        // Mid-operation asynchronous reset.
        preload(32'h11, 32'h22);
        bus.Start = 1'b1; bus.ALUControl = OP_MULT; bus.A = 32'd4; bus.B = 32'd4;
        tick();
        bus.Start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        #2 Rst = 1'b0;
        #1;
        check("async rst busy", 64'(bus.Busy), 64'd0);
        check("async rst done", 64'(bus.Done), 64'd0);
        check("async rst hi", 64'(bus.Hi), 64'd0);
        check("async rst lo", 64'(bus.Lo), 64'd0);
        tick();
        Rst = 1'b1;
        dones  = 0;
        busies = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (bus.Done) dones++;
            if (bus.Busy) busies++;
        end
        check("post-rst no done", 64'(dones), 64'd0);
        check("post-rst idle", 64'(busies), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
